pipe_ctrl_chain: RTL

//  Parametrised N-stage pipeline register chain with built-in hazard control for the RISC core.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_stage_reg.sv | 36 +++
 rtl/pipe_ctrl_chain.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline register chain and its hazard logic.
package pipe_pkg;

  // Forwarding select encodings for the EX-stage operand muxes.
  localparam logic [1:0] FWD_NONE  = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  // Stage indices along the chain.
  localparam int unsigned IDX_IFID  = 0;
  localparam int unsigned IDX_IDEX  = 1;
  localparam int unsigned IDX_EXMEM = 2;
  localparam int unsigned IDX_MEMWB = 3;

  // Metadata addresses are stored at a fixed width so the struct can live here;
  // narrower register files are zero-extended on entry. ADDR_W must not exceed this.
  localparam int unsigned MAX_ADDR_W = 8;

  typedef struct packed {
    logic                  valid;
    logic [MAX_ADDR_W-1:0] dst_addr;
    logic                  dst_we;
    logic                  is_load;
    logic [MAX_ADDR_W-1:0] src1_addr;
    logic                  src1_use;
    logic [MAX_ADDR_W-1:0] src2_addr;
    logic                  src2_use;
  } pipe_meta_t;

  // True when a used source register names the given destination.
  function automatic logic src_match(input logic                  src_used,
                                     input logic [MAX_ADDR_W-1:0] src,
                                     input logic [MAX_ADDR_W-1:0] dst);
    return src_used & (src == dst);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register: loads, holds, or loads as a bubble (valid cleared).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 bubble,
  input  pipe_meta_t           d_meta,
  input  logic [PAYLOAD_W-1:0] d_payload,
  output pipe_meta_t           q_meta,
  output logic [PAYLOAD_W-1:0] q_payload
);

  pipe_meta_t meta_d;

  // Incoming metadata with valid suppressed when this load is a bubble.
  always_comb begin
    meta_d       = d_meta;
    meta_d.valid = d_meta.valid & ~bubble;
  end

  // Stage state: cleared on reset, otherwise loaded or held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_meta    <= '0;
      q_payload <= '0;
    end else if (load) begin
      q_meta    <= meta_d;
      q_payload <= d_payload;
    end
  end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// N-stage pipeline register chain with load-use stall, flush and EX forwarding selects.
// Optional feature: define PIPE_PERF_CNT_EN to build the stall/flush/retire counters.
module pipe_ctrl_chain
  import pipe_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned PAYLOAD_W   = 64,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [PAYLOAD_W-1:0]            in_payload,
  input  logic [ADDR_W-1:0]               in_dst_addr,
  input  logic                            in_dst_we,
  input  logic                            in_is_load,
  input  logic [ADDR_W-1:0]               in_src1_addr,
  input  logic                            in_src1_use,
  input  logic [ADDR_W-1:0]               in_src2_addr,
  input  logic                            in_src2_use,
  output logic                            in_ready,
  input  logic                            freeze,
  input  logic                            flush_req,
  output logic [NUM_STAGES-1:0]           stage_valid,
  output logic [NUM_STAGES*PAYLOAD_W-1:0] stage_payload,
  output logic                            stall,
  output logic [1:0]                      fwd1_sel,
  output logic [1:0]                      fwd2_sel,
  output logic [31:0]                     perf_stall_cnt,
  output logic [31:0]                     perf_flush_cnt,
  output logic [31:0]                     perf_retire_cnt
);

  pipe_meta_t           meta_q    [NUM_STAGES];
  logic [PAYLOAD_W-1:0] payload_q [NUM_STAGES];
  pipe_meta_t           in_meta;
  logic [NUM_STAGES-1:0] stage_load;
  logic [NUM_STAGES-1:0] stage_bubble;

  // Pack the incoming instruction's metadata, zero-extending register addresses.
  always_comb begin
    in_meta                           = '0;
    in_meta.valid                     = in_valid;
    in_meta.dst_addr[ADDR_W-1:0]      = in_dst_addr;
    in_meta.dst_we                    = in_dst_we;
    in_meta.is_load                   = in_is_load;
    in_meta.src1_addr[ADDR_W-1:0]     = in_src1_addr;
    in_meta.src1_use                  = in_src1_use;
    in_meta.src2_addr[ADDR_W-1:0]     = in_src2_addr;
    in_meta.src2_use                  = in_src2_use;
  end

  // Load-use hazard: a load in ID/EX feeding the instruction in IF/ID.
  assign stall = meta_q[IDX_IDEX].valid & meta_q[IDX_IDEX].is_load &
                 meta_q[IDX_IDEX].dst_we & meta_q[IDX_IFID].valid &
                 (src_match(meta_q[IDX_IFID].src1_use, meta_q[IDX_IFID].src1_addr,
                            meta_q[IDX_IDEX].dst_addr) |
                  src_match(meta_q[IDX_IFID].src2_use, meta_q[IDX_IFID].src2_addr,
                            meta_q[IDX_IDEX].dst_addr));

  // A flush consumes and drops the input even while frozen or stalled.
  assign in_ready = flush_req | ~(freeze | stall);

  function automatic logic [1:0] fwd_select(input logic                  src_used,
                                            input logic [MAX_ADDR_W-1:0] src,
                                            input pipe_meta_t            exmem,
                                            input pipe_meta_t            memwb);
    // Load data is not yet available in EX/MEM, so such a producer is skipped.
    if (exmem.valid & exmem.dst_we & ~exmem.is_load & src_match(src_used, src, exmem.dst_addr)) begin
      return FWD_EXMEM;
    end else if (memwb.valid & memwb.dst_we & src_match(src_used, src, memwb.dst_addr)) begin
      return FWD_MEMWB;
    end
    return FWD_NONE;
  endfunction

  // Forwarding selects for the instruction currently in ID/EX.
  always_comb begin
    fwd1_sel = FWD_NONE;
    fwd2_sel = FWD_NONE;
    if (meta_q[IDX_IDEX].valid) begin
      fwd1_sel = fwd_select(meta_q[IDX_IDEX].src1_use, meta_q[IDX_IDEX].src1_addr,
                            meta_q[IDX_EXMEM], meta_q[IDX_MEMWB]);
      fwd2_sel = fwd_select(meta_q[IDX_IDEX].src2_use, meta_q[IDX_IDEX].src2_addr,
                            meta_q[IDX_EXMEM], meta_q[IDX_MEMWB]);
    end
  end

  // Per-stage load/bubble controls in priority order flush > freeze > stall > advance.
  always_comb begin
    stage_load   = '1;
    stage_bubble = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (flush_req) begin
        // Stage FLUSH_DEPTH receives the killed contents of stage FLUSH_DEPTH-1.
        stage_bubble[i] = (i <= FLUSH_DEPTH);
      end else if (freeze) begin
        stage_load[i] = 1'b0;
      end else if (stall) begin
        if (i == IDX_IFID) begin
          stage_load[i] = 1'b0;
        end else if (i == IDX_IDEX) begin
          stage_bubble[i] = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    pipe_meta_t           d_meta;
    logic [PAYLOAD_W-1:0] d_payload;

    if (g == 0) begin : g_head
      assign d_meta    = in_meta;
      assign d_payload = in_payload;
    end else begin : g_body
      assign d_meta    = meta_q[g-1];
      assign d_payload = payload_q[g-1];
    end

    pipe_stage_reg #(
      .PAYLOAD_W (PAYLOAD_W)
    ) u_stage_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (stage_load[g]),
      .bubble    (stage_bubble[g]),
      .d_meta    (d_meta),
      .d_payload (d_payload),
      .q_meta    (meta_q[g]),
      .q_payload (payload_q[g])
    );

    assign stage_valid[g]                            = meta_q[g].valid;
    assign stage_payload[g*PAYLOAD_W +: PAYLOAD_W] = payload_q[g];
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [31:0] retire_cnt_q;
  logic        last_adv;

  // The last stage moves on flush, stall or plain advance; only freeze holds it.
  assign last_adv = flush_req | ~freeze;

  // Wrap-around event counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (stall & ~flush_req & ~freeze) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_req) flush_cnt_q <= flush_cnt_q + 32'd1;
      if (meta_q[NUM_STAGES-1].valid & last_adv) retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_flush_cnt  = flush_cnt_q;
  assign perf_retire_cnt = retire_cnt_q;
`else
  assign perf_stall_cnt  = '0;
  assign perf_flush_cnt  = '0;
  assign perf_retire_cnt = '0;
`endif

endmodule
